seq_step_counter: RTL and testbench
===================================

Name: seq_step_counter

Overview:
- Sequence-index counter for the random-sequence counter datapath. Sits directly downstream of the sequence controller and closes the loop with it.
- Drives the 3-bit step index `count` into the controller. Consumes the controller's `in` (next sequence value) and `clear`.
- Captures each sequence value into `q` on a paced step boundary. Flags repeats and wrap-around for the display and check logic downstream.

Parameters:
- CW, 3, width of step index `count`.
- VW, 3, width of sequence value `in`/`q`.
- LAST, 5, last step index; index wraps LAST -> 0. Legal range 0..2^CW-1.
- DIV, 4, clocks per step. Legal range 2..255, so `in` has at least one full cycle to settle after `count` changes.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- clear, input, 1, from controller; synchronous, level-sensitive sequence restart.
- en, input, 1, step enable; low = freeze.
- in, input, VW, next sequence value from controller for the current `count`.
- count, output, CW, current step index, to controller.
- q, output, VW, last captured sequence value.
- q_valid, output, 1, one-cycle pulse: `q` updated this cycle.
- repeat, output, 1, valid with `q_valid`: new `q` equals previous `q` (held until next capture).
- wrap, output, 1, one-cycle pulse coincident with the `q_valid` of step LAST.
- busy, output, 1, high in RUN state.

Behaviour:
- All registers update on the rising edge of `clk`. Priority order: `reset` > `clear` > `en`.
- Reset (sync, active-high):
  - count=0, q=0, q_valid=0, repeat=0, wrap=0, busy=0.
  - Divider div=0, prev-valid flag=0, state=IDLE.
- FSM states:
  - IDLE: waits for `clear`=0 and `en`=1, then goes to RUN. No captures occur in IDLE.
  - RUN: divider counts 0..DIV-1.
    - `en`=0: divider and count freeze, state stays RUN, busy stays 1, no pulses.
    - `clear`=1: go to IDLE.
- Step boundary (RUN, en=1, div==DIV-1), all in the same edge:
  - q<=in; q_valid<=1.
  - repeat<=(prev-valid && in==q); prev-valid<=1.
  - wrap<=(count==LAST).
  - count<=(count==LAST)?0:count+1; div<=0.
  - Not a step boundary: div<=div+1.
- Timing:
  - First capture occurs DIV cycles after entering RUN.
  - `count` changes on the same edge as the capture, so the controller has DIV-1 clean cycles to present the next `in`.
- `clear`=1 (any state, no reset):
  - count=0, div=0, prev-valid=0, q_valid=0, wrap=0, state=IDLE.
  - q and repeat hold their values.
  - Release: RUN on the next edge with `clear`=0 and `en`=1.
- Boundary conditions:
  - Count width arithmetic is modulo 2^CW, but wrap is to 0 at LAST, not at 2^CW-1.
  - If count > LAST (only reachable if LAST is changed), the next step goes to 0 and wrap pulses.
  - LAST=0: count stays 0; wrap and q_valid pulse on every step.
  - `en` dropping on the boundary cycle: no capture; the step completes when `en` returns, with div still at DIV-1.
  - Reset or clear asserted on the boundary cycle: they win, no capture.
  - Pulses (`q_valid`, `wrap`) are exactly one cycle wide and cannot be back-to-back, since DIV>=2.

Test Plan:
- Reset check: reset=1 for 3 cycles with en=1, clear=0 -> count=0, q=0, all flags 0, busy=0. Release reset -> busy=1 on next edge, first q_valid after exactly 4 cycles.
- Closed loop with behavioural controller (0->5, 1->5, 2->2, 3->2, 4->6, 5->6), DIV=4, LAST=5: clear high 2 cycles then low, en=1.
  - Required q sequence: 5,5,2,2,6,6,5,...
  - repeat = 0,1,0,1,0,1,0.
  - count sequence: 1,2,3,4,5,0.
  - wrap on the 6th capture only; q_valid spacing = 4 cycles.
- Freeze: en=0 for 7 cycles at div=2, count=3 -> count, div and q unchanged, no pulses. Re-enable -> capture after 1 more cycle.
- Mid-run clear at count=4, div=1 -> next edge count=0, busy=0, q holds 2. Restart -> first capture has repeat=0 even if value equals held q.
- Reset mid-run at the boundary cycle (div=3) -> no q_valid, all outputs to reset values.
- LAST=0, DIV=2, in held at 3 -> count stays 0, q_valid and wrap every 2 cycles, repeat=1 from the second capture on.

Source files
------------

// File: rtl/seq_step_counter_if.sv
// Step-counter <-> sequence-controller link: restart/enable/value in,
// step index and captured sequence value with status flags out.
interface seq_step_counter_if #(
  parameter int CW = 3,
  parameter int VW = 3
) ();
  logic          clear;
  logic          en;
  logic [VW-1:0] in;
  logic [CW-1:0] count;
  logic [VW-1:0] q;
  logic          q_valid;
  logic          rpt;
  logic          wrap;
  logic          busy;

  modport master (
    output clear, en, in,
    input  count, q, q_valid, rpt, wrap, busy
  );

  modport slave (
    input  clear, en, in,
    output count, q, q_valid, rpt, wrap, busy
  );
endinterface

// File: rtl/seq_step_counter.sv
// Paced step-index counter: every DIV enabled cycles it captures the
// controller's value, advances the index (wrapping at LAST) and flags repeats.
module seq_step_counter #(
  parameter int CW   = 3,
  parameter int VW   = 3,
  parameter int LAST = 5,
  parameter int DIV  = 4
) (
  input logic               clk,
  input logic               reset,
  seq_step_counter_if.slave bus
);
  localparam int            DW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_END  = DW'(DIV - 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(LAST);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [CW-1:0] count;
  logic [VW-1:0] q;
  logic          q_valid, rpt, wrap, prev_valid;
  logic          last_hit;

  // An index beyond LAST (only possible if LAST shrinks) also wraps to 0.
  assign last_hit = (count == LAST_IDX) || (count > LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next-state is assigned a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!bus.clear && bus.en) state_nxt = RUN;
      RUN:  if (bus.clear)            state_nxt = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values (q is compared before it is overwritten).
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      div        <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      rpt        <= 1'b0;
      wrap       <= 1'b0;
      prev_valid <= 1'b0;
    end else if (bus.clear) begin
      // Restart the sequence; q and rpt keep showing the last capture.
      count      <= '0;
      div        <= '0;
      q_valid    <= 1'b0;
      wrap       <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      wrap    <= 1'b0;
      if (state == RUN && bus.en) begin
        if (div == DIV_END) begin
          q          <= bus.in;
          q_valid    <= 1'b1;
          rpt        <= prev_valid && (bus.in == q);
          prev_valid <= 1'b1;
          wrap       <= last_hit;
          count      <= last_hit ? '0 : count + 1'b1;
          div        <= '0;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  assign bus.count   = count;
  assign bus.q       = q;
  assign bus.q_valid = q_valid;
  assign bus.rpt     = rpt;
  assign bus.wrap    = wrap;
  assign bus.busy    = (state == RUN);
endmodule

// File: tb/tb_seq_step_counter.sv
// Directed bench: one counter closed-loop with a behavioural controller,
// a second one with LAST=0, DIV=2; captures are checked through scoreboards.
module tb_seq_step_counter;
  typedef struct {
    logic [2:0] q;
    logic       rpt;
    logic       wrap;
    logic [2:0] count;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  logic ovr;
  logic [2:0] ovr_val;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  seq_step_counter_if #(.CW(3), .VW(3)) bus_a ();
  seq_step_counter_if #(.CW(3), .VW(3)) bus_b ();

  seq_step_counter #(.CW(3), .VW(3), .LAST(5), .DIV(4)) dut_a (
    .clk(clk), .reset(reset_a), .bus(bus_a)
  );
  seq_step_counter #(.CW(3), .VW(3), .LAST(0), .DIV(2)) dut_b (
    .clk(clk), .reset(reset_b), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] ctrl_lut(input logic [2:0] c);
    case (c)
      3'd0, 3'd1: return 3'd5;
      3'd2, 3'd3: return 3'd2;
      3'd4, 3'd5: return 3'd6;
      default:    return 3'd0;
    endcase
  endfunction

  // Behavioural controller closing the loop, with a manual value override.
  always_comb bus_a.in = ovr ? ovr_val : ctrl_lut(bus_a.count);
  assign bus_b.in    = 3'd3;
  assign bus_b.clear = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_a(input string tag, input logic [2:0] count, input logic [2:0] q,
                         input logic qv, input logic rpt, input logic wrap, input logic busy);
    check({tag, "_count"},   bus_a.count,   count);
    check({tag, "_q"},       bus_a.q,       q);
    check({tag, "_q_valid"}, bus_a.q_valid, qv);
    check({tag, "_rpt"},     bus_a.rpt,     rpt);
    check({tag, "_wrap"},    bus_a.wrap,    wrap);
    check({tag, "_busy"},    bus_a.busy,    busy);
  endtask

  task automatic push_a(input logic [2:0] q, input logic rpt, input logic wrap,
                        input logic [2:0] count, input int c);
    exp_t e;
    e.q = q; e.rpt = rpt; e.wrap = wrap; e.count = count; e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [2:0] q, input logic rpt,
                         input logic wrap, input logic [2:0] count);
    check({tag, "_cap_q"},     q,     e.q);
    check({tag, "_cap_rpt"},   rpt,   e.rpt);
    check({tag, "_cap_wrap"},  wrap,  e.wrap);
    check({tag, "_cap_count"}, count, e.count);
    check({tag, "_cap_cycle"}, cyc,   e.cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_a.q_valid) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_capture: got q_valid=1 q=%0d at cycle %0d, required none", bus_a.q, cyc);
      end else begin
        e = qa.pop_front();
        compare("a", e, bus_a.q, bus_a.rpt, bus_a.wrap, bus_a.count);
      end
    end
    if (bus_b.q_valid) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_capture: got q_valid=1 q=%0d at cycle %0d, required none", bus_b.q, cyc);
      end else begin
        e = qb.pop_front();
        compare("b", e, bus_b.q, bus_b.rpt, bus_b.wrap, bus_b.count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.en = 1'b1; bus_a.clear = 1'b0;
    bus_b.en = 1'b1;
    ovr = 1'b0; ovr_val = 3'd0;

    // Reset held 3 cycles with en=1.
    wait_cyc(3);
    check_a("reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_a = 1'b0;
    push_a(3'd5, 1'b0, 1'b0, 3'd1, 8);
    wait_cyc(4);
    check("release_busy", bus_a.busy, 1'b1);
    check("release_no_capture", bus_a.q_valid, 1'b0);

    // Clear for 2 cycles right after the first capture.
    wait_cyc(8);
    bus_a.clear = 1'b1;
    wait_cyc(10);
    check_a("clear", 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_a.clear = 1'b0;
    push_a(3'd5, 1'b0, 1'b0, 3'd1, 15);
    push_a(3'd5, 1'b1, 1'b0, 3'd2, 19);
    push_a(3'd2, 1'b0, 1'b0, 3'd3, 23);
    push_a(3'd2, 1'b1, 1'b0, 3'd4, 27);
    push_a(3'd6, 1'b0, 1'b0, 3'd5, 31);
    push_a(3'd6, 1'b1, 1'b1, 3'd0, 35);
    push_a(3'd5, 1'b0, 1'b0, 3'd1, 39);
    push_a(3'd5, 1'b1, 1'b0, 3'd2, 43);
    push_a(3'd2, 1'b0, 1'b0, 3'd3, 47);

    // Freeze 7 cycles at count=3, div=2.
    wait_cyc(49);
    bus_a.en = 1'b0;
    for (int c = 50; c <= 56; c++) begin
      wait_cyc(c);
      check_a("freeze", 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    bus_a.en = 1'b1;
    push_a(3'd2, 1'b1, 1'b0, 3'd4, 58);

    // Mid-run clear at count=4, div=1; restart with a value equal to held q.
    wait_cyc(59);
    bus_a.clear = 1'b1;
    ovr = 1'b1; ovr_val = 3'd2;
    wait_cyc(60);
    check_a("midclear", 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_a.clear = 1'b0;
    push_a(3'd2, 1'b0, 1'b0, 3'd1, 65);
    wait_cyc(65);
    ovr = 1'b0;

    // Reset on the boundary cycle (div=3) must beat the capture.
    wait_cyc(68);
    reset_a = 1'b1;
    wait_cyc(69);
    check_a("boundary_reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Second instance: LAST=0, DIV=2, in held at 3.
    check("b_reset_count", bus_b.count, 3'd0);
    check("b_reset_q", bus_b.q, 3'd0);
    check("b_reset_busy", bus_b.busy, 1'b0);
    reset_b = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      e.q = 3'd3; e.rpt = (i > 1); e.wrap = 1'b1; e.count = 3'd0; e.cyc = 70 + 2 * i;
      qb.push_back(e);
    end
    wait_cyc(73);
    check("b_between_no_pulse", bus_b.q_valid, 1'b0);
    check("b_count_held", bus_b.count, 3'd0);
    wait_cyc(80);
    bus_b.en = 1'b0;

    wait_cyc(90);
    check("a_pending_captures", qa.size(), 0);
    check("b_pending_captures", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
